fetch_pair: RTL
===============

Name: fetch_pair

Overview:
- Dual-issue fetch stage that sits directly upstream of the decode/flow-control stage.
- Each access reads one 64-bit word (two consecutive RV32I instructions) from instruction memory and buffers pairs in a 2-entry queue.
- Presents the queue head as id_instr1/id_instr2 to decode; decode feeds the flow-control issue logic.
- Honours the flow-control stall and redirects on a taken branch resolved in EX.

Parameters:
- RESET_PC, 32'h0000_0000, byte address of the first fetched pair; bits [2:0] must be 0.
- NOP_INSTR, 32'h0000_0013, encoding substituted for squashed or empty slots (addi x0,x0,0).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- stall  in  1  from flow control; 1 = hold the current head pair, 0 = consume the head pair if id_valid
- ex_br_taken  in  1  taken branch resolved this cycle; causes a redirect
- ex_br_target  in  32  redirect byte address; bits [1:0] are ignored
- imem_req  out  1  read request this cycle
- imem_addr  out  32  8-byte-aligned pair address
- imem_rdata  in  64  read data one cycle after imem_req; [31:0] is instr at addr, [63:32] is instr at addr+4
- id_valid  out  1  head pair valid
- id_instr1  out  32  head slot 0 (older instruction)
- id_instr2  out  32  head slot 1
- id_pc1  out  32  byte PC of id_instr1; PC of id_instr2 is id_pc1+4

Behaviour:
- Reset (synchronous, rst=1 at the clock edge):
  - fetch_pc <= RESET_PC; queue emptied; in-flight flag cleared; epoch <= 0; squash_lo <= 0.
  - Outputs: imem_req=0, id_valid=0, id_instr1=id_instr2=NOP_INSTR, id_pc1=RESET_PC.
  - Reset asserted mid-operation discards everything, including an in-flight response.
- Request:
  - imem_req=1 when (occupancy + inflight - pop) < 2 and ex_br_taken=0, where pop = id_valid & ~stall.
  - imem_addr = fetch_pc. On each accepted request, fetch_pc += 8; the address wraps modulo 2^32.
- Response:
  - Arrives in the cycle after imem_req, tagged with the epoch captured at request time.
  - If the tag matches the current epoch and no redirect occurs this cycle, push {pc, rdata} into the queue.
  - If squash_lo is set, slot 0 is replaced by NOP_INSTR and squash_lo is cleared on push.
  - Otherwise the response is dropped.
- Queue:
  - 2-entry circular buffer with read/write pointers and a 2-bit count.
  - Push and pop in the same cycle keep the count unchanged.
  - Push is never attempted when full; credit counting guarantees this, and an assertion checks it.
- Output: the queue head is driven combinationally from registered storage. When empty, id_valid=0 and both slots are NOP_INSTR.
- Redirect (ex_br_taken=1) has the highest priority below reset:
  - Queue is flushed, epoch toggles (drops any in-flight data), no request is issued that cycle.
  - fetch_pc <= {ex_br_target[31:3],3'b000}; squash_lo <= ex_br_target[2].
  - stall and pop are ignored in that cycle.
- Latency:
  - From reset release: request in cycle 0, data in cycle 1, id_valid=1 in cycle 2.
  - From a redirect asserted in cycle R: request in R+1, id_valid in R+3.
- Throughput: 1 pair/cycle when stall=0 continuously; the flow control normally pops every other cycle.
- Stall held indefinitely: queue fills to 2 and imem_req stays 0; contents are stable.

Decomposition:
- Shared package (define.v): NOP_INSTR encoding and the pair width (64).
- One sub-module, pair_queue: 2-entry {pc, instr pair} FIFO with push, pop, flush, count, and head outputs.
- PC, epoch and credit logic stay in fetch_pair.

Test Plan:
- Reset release, stall=0, imem returns 64'h00200093_00100093 at addr 0 → cycle 2: id_valid=1, id_instr1=32'h00100093, id_instr2=32'h00200093, id_pc1=0; next request addr 8.
- stall=1 held 10 cycles after the first fill → count=2, imem_req=0 after 2 requests, id_pc1 stays 0; stall=0 → pops pc 0 then pc 8, requests resume at 16.
- Redirect ex_br_taken=1, target 32'h0000_0104 with a response in flight → in-flight data dropped; request at 32'h100; id_pc1=32'h100, id_instr1=NOP_INSTR, id_instr2=word at 0x104.
- Redirect and stall=1 in the same cycle while the queue is full → queue empty next cycle, id_valid=0, refetch from target.
- rst=1 asserted while queue is full and a request is in flight → next cycle: id_valid=0, outputs NOP, imem_req=0; the in-flight response is ignored.
- fetch_pc = 32'hFFFF_FFF8, continuous fetch → next imem_addr = 32'h0000_0000 (wrap).

Source files
------------

// File: rtl/fetch_pair_pkg.sv
// Shared types and constants for the dual-issue fetch stage.
// A fetched pair is one 64-bit memory word holding two consecutive RV32I instructions.
package fetch_pair_pkg;

  localparam int          PAIR_W  = 64;
  localparam logic [31:0] NOP_ENC = 32'h0000_0013;

  typedef struct packed {
    logic [31:0]       pc;
    logic [PAIR_W-1:0] data;
  } pair_t;

endpackage

// File: rtl/fetch_pair_queue.sv
// Two-entry circular FIFO of {pc, instruction pair} between fetch and decode.
// The head is read combinationally from registered storage.
module fetch_pair_queue
  import fetch_pair_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = NOP_ENC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [31:0]       push_pc,
  input  logic [PAIR_W-1:0] push_data,
  input  logic              pop,
  input  logic              flush,
  output logic [1:0]        count,
  output logic              head_valid,
  output logic [31:0]       head_pc,
  output logic [PAIR_W-1:0] head_data
);

  pair_t mem [2];
  logic  wr_ptr;
  logic  rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        mem[i] <= '{pc: RESET_PC, data: {NOP, NOP}};
      end
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{pc: push_pc, data: push_data};
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // Credit counting upstream must keep pushes away from a full queue.
  always_ff @(posedge clk) begin
    if (!rst && !flush && push) begin
      push_not_full: assert (count != 2'd2);
    end
  end

  assign head_valid = (count != 2'd0);
  assign head_pc    = mem[rd_ptr].pc;
  assign head_data  = mem[rd_ptr].data;

endmodule

// File: rtl/fetch_pair.sv
// Dual-issue fetch: requests 8-byte instruction pairs, buffers them in a 2-entry queue,
// and presents the head pair to decode. Taken branches flush and redirect.
module fetch_pair
  import fetch_pair_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_ENC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              ex_br_taken,
  input  logic [31:0]       ex_br_target,
  output logic              imem_req,
  output logic [31:0]       imem_addr,
  input  logic [PAIR_W-1:0] imem_rdata,
  output logic              id_valid,
  output logic [31:0]       id_instr1,
  output logic [31:0]       id_instr2,
  output logic [31:0]       id_pc1
);

  logic [31:0]       fetch_pc;
  logic [31:0]       resp_pc;
  logic              inflight;
  logic              resp_epoch;
  logic              epoch;
  logic              squash_lo;
  logic [1:0]        count;
  logic              head_valid;
  logic [31:0]       head_pc;
  logic [PAIR_W-1:0] head_data;
  logic              pop;
  logic              push;
  logic [2:0]        credit;
  logic [PAIR_W-1:0] push_data;
  logic              unused_tgt_bits;

  assign unused_tgt_bits = ^ex_br_target[1:0];

  assign pop       = head_valid & ~stall & ~ex_br_taken;
  assign credit    = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  assign imem_req  = ~rst & ~ex_br_taken & (credit < 3'd2);
  assign imem_addr = fetch_pc;

  // Stale-epoch responses belong to a path abandoned by a redirect.
  assign push      = inflight & (resp_epoch == epoch) & ~ex_br_taken & ~rst;
  assign push_data = {imem_rdata[63:32], squash_lo ? NOP_INSTR : imem_rdata[31:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc   <= RESET_PC;
      resp_pc    <= RESET_PC;
      inflight   <= 1'b0;
      resp_epoch <= 1'b0;
      epoch      <= 1'b0;
      squash_lo  <= 1'b0;
    end else if (ex_br_taken) begin
      fetch_pc  <= {ex_br_target[31:3], 3'b000};
      squash_lo <= ex_br_target[2];
      epoch     <= ~epoch;
      inflight  <= 1'b0;
    end else begin
      inflight <= imem_req;
      if (imem_req) begin
        fetch_pc   <= fetch_pc + 32'd8;
        resp_pc    <= fetch_pc;
        resp_epoch <= epoch;
      end
      if (push) begin
        squash_lo <= 1'b0;
      end
    end
  end

  fetch_pair_queue #(
    .RESET_PC (RESET_PC),
    .NOP      (NOP_INSTR)
  ) u_queue (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_pc    (resp_pc),
    .push_data  (push_data),
    .pop        (pop),
    .flush      (ex_br_taken),
    .count      (count),
    .head_valid (head_valid),
    .head_pc    (head_pc),
    .head_data  (head_data)
  );

  assign id_valid  = head_valid;
  assign id_instr1 = head_valid ? head_data[31:0]  : NOP_INSTR;
  assign id_instr2 = head_valid ? head_data[63:32] : NOP_INSTR;
  assign id_pc1    = head_pc;

endmodule
